// File: rtl/voronoi_leader_sched.sv
// voronoi_leader_sched: round-robin, mutually exclusive leader grant for the red/green/yellow Voronoi lineages.
// Optional ACTIVE timeout enabled by defining VORONOI_SCHED_TIMEOUT_EN.
module voronoi_leader_sched #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int COOL_CYC    = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       band,
  input  logic [2:0]       leader_signal,
  input  logic [2:0]       rep_leader,
  output logic [2:0]       select_leader,
  output logic             busy,
  output logic [2:0]       last_grant,
  output logic [CNT_W-1:0] round_count,
  output logic             timeout_err
);
  typedef enum logic [2:0] {IDLE, SENSE, SELECT, ACTIVE, COOL} state_t;
  localparam int MAX_A = SETTLE_CYC > COOL_CYC ? SETTLE_CYC : COOL_CYC;
  localparam int MAX_V = MAX_A > TIMEOUT_CYC ? MAX_A : TIMEOUT_CYC;
  localparam int CW = $clog2(MAX_V + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] band_q, band_d, grant_q, grant_d, sel_q, sel_d, last_q, last_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic terr_q, terr_d;
  logic [2:0] elig, nxt, nxt2, pick;
  logic ack, lost, tmo;
  // Eligibility, round-robin pick starting after last_grant, and ACTIVE exit conditions.
  always_comb begin
    elig = leader_signal & {band[1] & band[0], band[2] & band[0], band[2] & band[1]};
    nxt  = {last_q[1:0], last_q[2]};
    nxt2 = {nxt[1:0], nxt[2]};
    pick = |(elig & nxt) ? nxt : |(elig & nxt2) ? nxt2 : |(elig & last_q) ? last_q : 3'b000;
    ack  = |(rep_leader & grant_q);
    lost = ~|(elig & grant_q);
`ifdef VORONOI_SCHED_TIMEOUT_EN
    tmo  = cnt_q == CW'(TIMEOUT_CYC - 1);
`else
    tmo  = 1'b0;
`endif
  end
  // Next-state and next-output logic; the grant is only driven while ACTIVE persists.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    band_d  = band;
    grant_d = grant_q;
    sel_d   = 3'b000;
    last_d  = last_q;
    rc_d    = rc_q;
    terr_d  = terr_q;
    if (!enable) state_d = IDLE;
    else case (state_q)
      IDLE: begin
        state_d = SENSE;
        cnt_d   = '0;
      end
      SENSE: begin
        state_d = band == band_q && cnt_q == CW'(SETTLE_CYC - 1) ? SELECT : SENSE;
        cnt_d   = band != band_q || cnt_q == CW'(SETTLE_CYC - 1) ? '0 : cnt_q + 1'b1;
      end
      SELECT: begin
        state_d = |pick ? ACTIVE : SENSE;
        grant_d = pick;
        sel_d   = pick;
        cnt_d   = '0;
      end
      ACTIVE: begin
        state_d = ack || lost || tmo ? COOL : ACTIVE;
        cnt_d   = ack || lost || tmo ? '0 : cnt_q + 1'b1;
        sel_d   = ack || lost || tmo ? 3'b000 : grant_q;
        last_d  = ack || (!lost && tmo) ? grant_q : last_q;
        rc_d    = ack ? rc_q + 1'b1 : rc_q;
        terr_d  = terr_q | (!ack && !lost && tmo);
      end
      COOL: begin
        state_d = cnt_q == CW'(COOL_CYC - 1) ? SENSE : COOL;
        cnt_d   = cnt_q == CW'(COOL_CYC - 1) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // All state and registered outputs; reset clears the grant asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      band_q  <= 3'b000;
      grant_q <= 3'b000;
      sel_q   <= 3'b000;
      last_q  <= 3'b100;
      rc_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      band_q  <= band_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rc_q    <= rc_d;
      terr_q  <= terr_d;
    end
  end
  assign select_leader = sel_q;
  assign busy          = state_q != IDLE;
  assign last_grant    = last_q;
  assign round_count   = rc_q;
  assign timeout_err   = terr_q;
endmodule

// File: doc/voronoi_leader_sched.md
# voronoi_leader_sched

Sequential controller that chooses which colour lineage (red, green, yellow) is allowed to assert its leader-select input in the Voronoi growth circuit. It watches the three band signals and the per-colour leader signals, waits for the band pattern to settle, and grants leadership to exactly one eligible colour per round, rotating priority round-robin. It then holds the grant until that colour's replication acknowledge (rep_leader) returns. It sits above the per-colour Leader/Band/SelectLeader blocks and replaces their free-running AND-based select with a sequenced, mutually exclusive grant.

## Interface
Parameters:
- SETTLE_CYC, 4, consecutive cycles the band vector must be unchanged before a selection.
- TIMEOUT_CYC, 64, maximum ACTIVE cycles awaiting rep_leader (only used with the timeout feature).
- COOL_CYC, 2, idle cycles after each round before sensing resumes.
- CNT_W, 8, width of round_count.

Ports (bit 0 = red, bit 1 = green, bit 2 = yellow on all 3-bit vectors):
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scheduler run enable.
- band  in  3  band signals {yellow, green, red}.
- leader_signal  in  3  per-colour leader signal.
- rep_leader  in  3  per-colour replication acknowledge.
- select_leader  out  3  one-hot (or zero) leader grant, registered.
- busy  out  1  high in any state other than IDLE.
- last_grant  out  3  one-hot colour of the most recent completed grant.
- round_count  out  CNT_W  completed rounds, wraps to 0.
- timeout_err  out  1  sticky, set on ACTIVE timeout; cleared only by reset.

## Operation
- Eligibility (combinational): elig[i] = leader_signal[i] AND band of both other colours high (red needs green & yellow, and so on).
- States: IDLE, SENSE, SELECT, ACTIVE, COOL.
- IDLE: enable=1 -> SENSE, settle counter cleared.
- SENSE: settle counter increments while band equals its previous-cycle value, and clears to 0 on any change. At count SETTLE_CYC-1 with no change -> SELECT.
- SELECT (one cycle): round-robin search starting at the colour after last_grant (red->green->yellow->red). The first colour with elig set becomes the grant -> ACTIVE. If no colour is eligible -> SENSE with the counter cleared.
- ACTIVE: select_leader = grant one-hot.
  - rep_leader[grant]=1 -> COOL, last_grant<=grant, round_count+1.
  - elig[grant] drops before the ack -> abort to COOL; last_grant and round_count are unchanged.
- COOL: select_leader=0 for COOL_CYC cycles -> SENSE.
- enable=0 in any state -> IDLE on the next edge, with select_leader=0 in that cycle. Counters are kept.
- rep_leader bits of non-granted colours are ignored.
- At most one bit of select_leader is ever high.

## Timing
- Reset values: select_leader=0, busy=0, last_grant=3'b100 (so the first grant search starts at red), round_count=0, timeout_err=0, state IDLE.
- With band stable from SENSE entry (cycle 0), SELECT is at cycle SETTLE_CYC and select_leader rises at cycle SETTLE_CYC+1.
- select_leader falls on the edge after rep_leader[grant] is sampled high (1-cycle latency).
- Ack, elig drop and timeout in the same cycle: ack wins, then elig drop, then timeout.
- round_count wraps from 2^CNT_W-1 to 0 without a flag.
- Reset asserted mid-ACTIVE clears select_leader immediately (asynchronously).

## Configuration
- VORONOI_SCHED_TIMEOUT_EN defined: a timeout counter runs in ACTIVE. After TIMEOUT_CYC cycles without an ack, the block sets timeout_err, moves to COOL and sets last_grant<=grant so the next search skips the stalled colour. round_count is not incremented.
- Not defined: ACTIVE waits indefinitely, timeout_err is tied to 0, and TIMEOUT_CYC is unused.

## Test plan
- Reset, enable=1, band=3'b110, leader_signal=3'b111, ack on the grant: select_leader=3'b001 (red) at cycle 5 after SENSE entry. After the ack, round_count=1 and last_grant=3'b001.
- band=3'b111, leader_signal=3'b111, acking every round: grants go red, green, yellow, red over four rounds, and round_count=4.
- Band toggles every 3 cycles with SETTLE_CYC=4: select_leader stays 0 and the block stays in SENSE.
- Red granted, then band[1] drops before the ack: select_leader goes to 0 the next cycle, round_count is unchanged, and the next search starts at green.
- Macro defined, TIMEOUT_CYC=64, no ack: timeout_err=1 after 64 ACTIVE cycles and the next grant skips the stalled colour. Macro undefined: select_leader is still high at cycle 200.
- rst_n pulsed low mid-ACTIVE: all outputs return to their reset values immediately, and the block is back in IDLE.
